// File: rtl/jk_pkg.sv
// Shared JK storage definitions: cell operation codes, their J/K encoding and
// the helper that picks the non-toggling operation that moves a bit to its next value.
package jk_pkg;

  localparam int DECADE_MOD = 10;

  typedef enum logic [1:0] {
    JK_HOLD,
    JK_SET,
    JK_RESET,
    JK_TOGGLE
  } jk_op_t;

  // Returns {J, K}.
  function automatic logic [1:0] jk_encode(input jk_op_t op);
    logic [1:0] jk;
    case (op)
      JK_HOLD:   jk = 2'b00;
      JK_SET:    jk = 2'b10;
      JK_RESET:  jk = 2'b01;
      JK_TOGGLE: jk = 2'b11;
      default:   jk = 2'b00;
    endcase
    return jk;
  endfunction

  // Only set/reset/hold are produced, so a glitch on one bit can never toggle it.
  function automatic jk_op_t jk_op_for(input logic nxt, input logic cur);
    jk_op_t op;
    if (nxt && !cur)      op = JK_SET;
    else if (!nxt && cur) op = JK_RESET;
    else                  op = JK_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high clear.
// Truth table {J,K}: 00 hold, 01 reset, 10 set, 11 toggle.
module jk_cell (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_j,
  input  logic i_k,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_q <= 1'b0;
    end else begin
      case ({i_j, i_k})
        2'b00:   r_q <= r_q;
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        default: r_q <= ~r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/jk_decade_counter.sv
// Loadable, cascadable modulo-N up/down counter whose state lives in JK cells.
// Priority per edge: clr > load > en > hold; tc is a combinational carry for chaining.
module jk_decade_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = DECADE_MOD
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             err
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_bad_load;
  logic             r_err;

  assign w_bad_load = load && ({1'b0, d} >= MOD_EXT);

  // Next count ignoring clr; clr is applied directly on the J/K pins below.
  always_comb begin
    w_next = w_q;
    if (load) begin
      w_next = w_bad_load ? '0 : d;
    end else if (en) begin
      if (up) w_next = (w_q == MAX_Q) ? '0 : w_q + WIDTH'(1);
      else    w_next = (w_q == '0) ? MAX_Q : w_q - WIDTH'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_op_t w_op;
    assign w_op = clr ? JK_RESET : jk_op_for(w_next[i], w_q[i]);
    assign {w_j[i], w_k[i]} = jk_encode(w_op);

    jk_cell u_cell (
      .i_clk (clk),
      .i_clr (clr),
      .i_j   (w_j[i]),
      .i_k   (w_k[i]),
      .o_q   (w_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (clr)             r_err <= 1'b0;
    else if (w_bad_load) r_err <= 1'b1;
  end

  assign q   = w_q;
  assign err = r_err;
  assign tc  = en & ((up & (w_q == MAX_Q)) | (!up & (w_q == '0)));

endmodule

// File: doc/jk_decade_counter.md
# jk_decade_counter

Synchronous modulo-N up/down counter whose state bits are held in JK flip-flop cells. Each cell's J/K inputs are derived from the current count and the control inputs. The block consumes the same JK storage primitive the team already uses and extends it into a loadable, cascadable decade stage with a terminal-count output for chaining digits. It sits directly downstream of the single JK cell, as its first multi-bit consumer.

## Interface

Parameters:
- WIDTH, 4, number of state bits / JK cells
- MODULUS, 10, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2^WIDTH

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  reset, synchronous and active-high; forces count to 0 and clears the error flag
- en  input  1  count enable; also the carry-in when stages are cascaded
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load of d
- d  input  WIDTH  load value
- q  output  WIDTH  current count, registered
- tc  output  1  terminal count, combinational: en & ((up & q==MODULUS-1) | (!up & q==0))
- err  output  1  sticky flag, registered; set when a load value is >= MODULUS

## Operation

- Priority on each rising edge: clr > load > en > hold.
- clr=1:
  - q <= 0, err <= 0.
  - load and en are ignored.
- load=1:
  - If d < MODULUS: q <= d.
  - If d >= MODULUS: q <= 0 and err <= 1.
  - en is ignored in the load cycle.
- en=1, up=1:
  - If q == MODULUS-1, q <= 0 (wrap).
  - Otherwise q <= q+1.
- en=1, up=0:
  - If q == 0, q <= MODULUS-1 (wrap).
  - Otherwise q <= q-1.
- en=0: q holds. tc=0.
- err is cleared only by clr; it stays set through later loads, counts and holds.
- State update mechanism:
  - Compute next = f(q, ctrl).
  - Per bit i, drive the JK cell with: J=1,K=0 if next[i]=1 and q[i]=0; J=0,K=1 if next[i]=0 and q[i]=1; J=K=0 otherwise.
  - Toggle (J=K=1) is never issued. Synchronous clear is applied by driving J=0,K=1 on every bit.
- A q value >= MODULUS is unreachable. There is no recovery path beyond clr.
- Cascading: tc of digit n drives en of digit n+1. All digits share clk and clr.

## Timing

- Reset values: q=0, err=0. tc=0 whenever en=0, so tc=0 right after reset unless en is already high and the terminal condition holds.
- Latency:
  - q reflects clr, load or a count one clock after the triggering edge.
  - tc is combinational, with zero latency from q, en and up.
  - err is set on the same edge that performs the out-of-range load.
- Simultaneous events:
  - clr with load/en → clear wins.
  - load with en → load wins; no count that cycle.
- Direction change takes effect on the next enabled edge. No extra cycle is inserted.
- clr asserted mid-count → q=0 on the next edge. Counting resumes on the first edge after clr deasserts with en=1.
- No combinational path from d to q. The only combinational outputs are tc, from en, up and q.

## Structure

- Shared package jk_pkg:
  - jk_op_t enum: JK_HOLD, JK_SET, JK_RESET, JK_TOGGLE.
  - Function mapping jk_op_t to a {J,K} pair.
  - DECADE_MOD = 10 constant.
- Sub-module jk_cell: one JK flip-flop with synchronous active-high clear, instantiated WIDTH times via generate. Its truth table is hold / reset / set / toggle.
- Top level holds the next-state logic, the JK encoding, the err register and the tc decode.

## Test plan

- Reset: hold clr=1 for 2 cycles, en=1, up=1 → q=0, err=0. First edge after release → q=1.
- Up wrap: load 8, then en=1, up=1 for 3 cycles → q=9 with tc=1, then q=0, then q=1.
- Down wrap: load 1, then en=1, up=0 for 3 cycles → q=0 with tc=1, then q=9, then q=8.
- Priority: set q=5, then drive load=1, d=3, en=1 together → q=3 (no count). Next drive clr=1, load=1, d=7 → q=0.
- Bad load: load d=12 → q=0, err=1. Then 4 enabled up counts → q=4, err still 1. Then clr → err=0.
- Cascade: two instances, low tc driving high en. Start from 00 and apply 25 enabled up edges → high=2, low=5. Continue from 99 for one more edge → 00.
